i2c_frame_ctr: RTL and testbench



---
 rtl/i2c_frame_ctr_if.sv | 42 ++++
 rtl/i2c_frame_ctr.sv | 83 ++++++++
 tb/tb_i2c_frame_ctr.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/i2c_frame_ctr_if.sv
// ---------------------------------------------------------------------------
// i2c_frame_ctr_if
//
// Purpose:
//   Bundles the handshake between the I2C slave FSM and the bit/byte frame
//   counter. The FSM (master side) drives the strobes and the clear. The
//   counter (slave side) returns the byte-complete and frame-complete levels.
//
// Signals:
//   clr_in       FSM -> counter  synchronous clear of all counters
//   next_in      FSM -> counter  one-cycle strobe, one received SCL bit
//   byteen_in    FSM -> counter  1 = a completed byte counts toward the frame
//   byteok_out   counter -> FSM  a full byte has been received (level)
//   frameok_out  counter -> FSM  a full frame has been received (level)
//
// Modports:
//   master  I2C FSM side
//   slave   frame counter side
// ---------------------------------------------------------------------------
interface i2c_frame_ctr_if;
    logic clr_in;
    logic next_in;
    logic byteen_in;
    logic byteok_out;
    logic frameok_out;

    modport master (
        output clr_in,
        output next_in,
        output byteen_in,
        input  byteok_out,
        input  frameok_out
    );

    modport slave (
        input  clr_in,
        input  next_in,
        input  byteen_in,
        output byteok_out,
        output frameok_out
    );
endinterface

// File: rtl/i2c_frame_ctr.sv
// ---------------------------------------------------------------------------
// i2c_frame_ctr
//
// Purpose:
//   Bit/byte counter for the I2C slave front-end of the filter register
//   interface. Counts received SCL bit strobes into bytes, counts completed
//   bytes into a frame, and reports a completed byte and a completed frame to
//   the I2C FSM as Moore levels decoded straight from the counter registers.
//
// Parameters:
//   BITS_PER_BYTE    data bits per byte (the ACK bit is not included)
//   BYTES_PER_FRAME  bytes per complete frame (address + register + data)
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous reset, active HIGH despite the name
//   bus     slave side of i2c_frame_ctr_if:
//             clr_in, next_in, byteen_in   (inputs)
//             byteok_out, frameok_out      (outputs)
// ---------------------------------------------------------------------------
module i2c_frame_ctr #(
    parameter int unsigned BITS_PER_BYTE   = 8,
    parameter int unsigned BYTES_PER_FRAME = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    i2c_frame_ctr_if.slave       bus
);

    localparam int BIT_W  = $clog2(BITS_PER_BYTE + 1);
    localparam int BYTE_W = $clog2(BYTES_PER_FRAME + 1);

    localparam logic [BIT_W-1:0]  BIT_FULL   = BIT_W'(BITS_PER_BYTE);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(BITS_PER_BYTE - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);
    localparam logic [BYTE_W-1:0] BYTE_FULL  = BYTE_W'(BYTES_PER_FRAME);
    localparam logic [BYTE_W-1:0] BYTE_ONE   = BYTE_W'(1);

    logic [BIT_W-1:0]  bit_ctr_q;
    logic [BIT_W-1:0]  bit_ctr_d;
    logic [BYTE_W-1:0] byte_ctr_q;
    logic [BYTE_W-1:0] byte_ctr_d;

    // Next-state logic. Clear beats a simultaneous strobe. When the bit
    // counter already sits at BITS_PER_BYTE, the strobe is the ACK bit and
    // only wraps the bit counter. byteen_in matters only on the strobe that
    // completes the data bits; the byte counter saturates so frameok_out
    // holds until the FSM clears it.
    always_comb begin
        bit_ctr_d  = bit_ctr_q;
        byte_ctr_d = byte_ctr_q;
        if (bus.clr_in) begin
            bit_ctr_d  = '0;
            byte_ctr_d = '0;
        end else if (bus.next_in) begin
            if (bit_ctr_q == BIT_FULL) begin
                bit_ctr_d = '0;
            end else begin
                bit_ctr_d = bit_ctr_q + BIT_ONE;
                if ((bit_ctr_q == BIT_LAST) && bus.byteen_in &&
                    (byte_ctr_q != BYTE_FULL)) begin
                    byte_ctr_d = byte_ctr_q + BYTE_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            bit_ctr_q  <= '0;
            byte_ctr_q <= '0;
        end else begin
            bit_ctr_q  <= bit_ctr_d;
            byte_ctr_q <= byte_ctr_d;
        end
    end

    // Outputs depend on the registers only, so the FSM never sees a
    // combinational path from its own strobes back into these levels.
    assign bus.byteok_out  = (bit_ctr_q == BIT_FULL);
    assign bus.frameok_out = (byte_ctr_q == BYTE_FULL);

endmodule

// File: tb/tb_i2c_frame_ctr.sv
// ---------------------------------------------------------------------------
// tb_i2c_frame_ctr
//
// Purpose:
//   Directed self-checking bench for i2c_frame_ctr. Inputs change on the
//   falling clock edge and outputs are sampled on the falling edge, half a
//   period away from the rising edge the design uses.
// ---------------------------------------------------------------------------
module tb_i2c_frame_ctr;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    i2c_frame_ctr_if bus ();

    i2c_frame_ctr #(
        .BITS_PER_BYTE   (8),
        .BYTES_PER_FRAME (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    // Holds next_in high for n consecutive rising edges and returns on the
    // falling edge after the last one, with next_in low again.
    task automatic run_strobes(input int n);
        @(negedge clk);
        bus.next_in = 1'b1;
        repeat (n) @(negedge clk);
        bus.next_in = 1'b0;
    endtask

    // One full byte (8 data bits + ACK) with byteok_out checked around the
    // 8th data bit and the ACK.
    task automatic run_byte(input logic en, input string tag);
        bus.byteen_in = en;
        run_strobes(7);
        check({tag, "_bit7_byteok"}, bus.byteok_out, 1'b0);
        run_strobes(1);
        check({tag, "_bit8_byteok"}, bus.byteok_out, 1'b1);
        run_strobes(1);
        check({tag, "_ack_byteok"}, bus.byteok_out, 1'b0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clr_in = 1'b1;
        @(negedge clk);
        bus.clr_in = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b1;
        bus.clr_in    = 1'b0;
        bus.next_in   = 1'b0;
        bus.byteen_in = 1'b0;

        // Reset state and idle stability
        @(negedge clk);
        rst_n = 1'b0;
        check("reset_byteok", bus.byteok_out, 1'b0);
        check("reset_frameok", bus.frameok_out, 1'b0);
        repeat (10) @(negedge clk);
        check("idle_byteok", bus.byteok_out, 1'b0);
        check("idle_frameok", bus.frameok_out, 1'b0);

        // Single byte: byteok after 8th strobe, dropped by ACK
        run_byte(1'b1, "single");
        check("single_frameok", bus.frameok_out, 1'b0);
        repeat (5) @(negedge clk);
        check("single_idle_byteok", bus.byteok_out, 1'b0);

        // Full frame: 2 more bytes then the 24th strobe of the frame
        pulse_clear();
        run_byte(1'b1, "f_b1");
        run_byte(1'b1, "f_b2");
        check("frame_b2_frameok", bus.frameok_out, 1'b0);
        bus.byteen_in = 1'b1;
        run_strobes(7);
        check("frame_23_frameok", bus.frameok_out, 1'b0);
        run_strobes(1);
        check("frame_24_frameok", bus.frameok_out, 1'b1);
        check("frame_24_byteok", bus.byteok_out, 1'b1);
        run_strobes(1);
        check("frame_ack_byteok", bus.byteok_out, 1'b0);
        check("frame_ack_frameok", bus.frameok_out, 1'b1);
        run_strobes(8);
        check("frame_extra8_byteok", bus.byteok_out, 1'b1);
        check("frame_extra8_frameok", bus.frameok_out, 1'b1);
        run_strobes(1);
        check("frame_extra9_byteok", bus.byteok_out, 1'b0);
        check("frame_extra9_frameok", bus.frameok_out, 1'b1);
        repeat (4) @(negedge clk);
        check("frame_idle_frameok", bus.frameok_out, 1'b1);
        pulse_clear();
        check("frame_clr_frameok", bus.frameok_out, 1'b0);
        check("frame_clr_byteok", bus.byteok_out, 1'b0);

        // byteen_in low on byte 2: 27 strobes give no frame, a 4th byte does
        run_byte(1'b1, "en_b1");
        run_byte(1'b0, "en_b2");
        run_byte(1'b1, "en_b3");
        check("en_27_frameok", bus.frameok_out, 1'b0);
        bus.byteen_in = 1'b1;
        run_strobes(8);
        check("en_b4_frameok", bus.frameok_out, 1'b1);
        run_strobes(1);
        pulse_clear();

        // Clear together with a strobe after 5 bits restarts the byte
        bus.byteen_in = 1'b1;
        run_strobes(5);
        @(negedge clk);
        bus.clr_in  = 1'b1;
        bus.next_in = 1'b1;
        @(negedge clk);
        bus.clr_in  = 1'b0;
        bus.next_in = 1'b0;
        check("clrnext_byteok", bus.byteok_out, 1'b0);
        run_strobes(3);
        check("clrnext_3_byteok", bus.byteok_out, 1'b0);
        run_strobes(4);
        check("clrnext_7_byteok", bus.byteok_out, 1'b0);
        run_strobes(1);
        check("clrnext_8_byteok", bus.byteok_out, 1'b1);
        run_strobes(1);
        pulse_clear();

        // Async reset mid-cycle after one counted byte, with byteok high
        run_byte(1'b1, "ar_b1");
        bus.byteen_in = 1'b1;
        run_strobes(8);
        check("ar_pre_byteok", bus.byteok_out, 1'b1);
        #2 rst_n = 1'b1;
        #1;
        check("ar_immediate_byteok", bus.byteok_out, 1'b0);
        check("ar_immediate_frameok", bus.frameok_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        run_byte(1'b1, "ar_n1");
        run_byte(1'b1, "ar_n2");
        check("ar_2bytes_frameok", bus.frameok_out, 1'b0);
        bus.byteen_in = 1'b1;
        run_strobes(8);
        check("ar_3bytes_frameok", bus.frameok_out, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
